traffic_intersection_ctrl: RTL and testbench

Phase scheduler for a two-road intersection. It owns the right-of-way for road A and road B and sequences green, yellow and all-red intervals, plus an exclusive pedestrian walk phase. Vehicle sensors and a latched pedestrian request drive the sequence. It replaces the fixed-cycle `traffic_light` sequencing and drives the same 3-bit lamp buses.

---
 rtl/traffic_pkg.sv | 22 ++
 rtl/phase_timer.sv | 27 ++
 rtl/traffic_intersection_ctrl.sv | 120 ++++++++++++
 tb/tb_traffic_intersection_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state encoding, lamp codes and helpers for the intersection controller
package traffic_pkg;

    typedef enum logic [2:0] {
        A_GRN  = 3'd0,
        A_YEL  = 3'd1,
        RED_AB = 3'd2,
        B_GRN  = 3'd3,
        B_YEL  = 3'd4,
        RED_BA = 3'd5,
        WALK   = 3'd6
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - tick-enabled, clearable interval counter that saturates at a supplied limit
module phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_tick,
    input  logic         i_clear,
    input  logic [W-1:0] i_limit,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_tick && (r_count < i_limit)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// rtl/traffic_intersection_ctrl.sv - demand-driven two-road phase scheduler with exclusive pedestrian walk
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 8,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       sens_a,
    input  logic       sens_b,
    input  logic       ped_req,
    output logic [2:0] lightA,
    output logic [2:0] lightB,
    output logic       walk,
    output logic [2:0] phase
);

    localparam int MAXP = max2(max2(GREEN_MAX, YELLOW_T), max2(ALLRED_T, WALK_T));
    localparam int TW   = $clog2(MAXP) + 1;

    localparam logic [TW-1:0] T_GMIN = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] T_GMAX = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] T_YEL  = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] T_RED  = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] T_WALK = TW'(WALK_T - 1);

    state_t        r_state;
    state_t        w_next;
    logic          r_ped_pending;
    logic          r_next_b;
    logic          w_trans;
    logic          w_a_exit;
    logic          w_b_exit;
    logic [TW-1:0] w_count;
    logic [TW-1:0] w_limit;

    // Greens rest at GREEN_MAX-1 so a late-arriving demand still sees the max-green exit.
    assign w_limit = ((r_state == A_GRN) || (r_state == B_GRN)) ? T_GMAX : '1;

    phase_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_tick  (tick),
        .i_clear (w_trans),
        .i_limit (w_limit),
        .o_count (w_count)
    );

    assign w_a_exit = (sens_b | r_ped_pending) &&
                      (((w_count >= T_GMIN) && !sens_a) || (w_count == T_GMAX));
    assign w_b_exit = (sens_a | r_ped_pending) &&
                      (((w_count >= T_GMIN) && !sens_b) || (w_count == T_GMAX));

    always_comb begin
        w_next = r_state;
        if (tick) begin
            case (r_state)
                A_GRN:   if (w_a_exit) w_next = A_YEL;
                A_YEL:   if (w_count == T_YEL) w_next = RED_AB;
                RED_AB:  if (w_count == T_RED) w_next = r_ped_pending ? WALK : B_GRN;
                B_GRN:   if (w_b_exit) w_next = B_YEL;
                B_YEL:   if (w_count == T_YEL) w_next = RED_BA;
                RED_BA:  if (w_count == T_RED) w_next = r_ped_pending ? WALK : A_GRN;
                WALK:    if (w_count == T_WALK) w_next = r_next_b ? B_GRN : A_GRN;
                default: w_next = A_GRN;
            endcase
        end
    end

    assign w_trans = (w_next != r_state);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= A_GRN;
        end else begin
            r_state <= w_next;
        end
    end

    // next_b remembers which road is owed green once a walk phase finishes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ped_pending <= 1'b0;
            r_next_b      <= 1'b0;
        end else begin
            if (w_trans && (w_next == WALK)) begin
                r_ped_pending <= 1'b0;
            end else if (ped_req && (r_state != WALK)) begin
                r_ped_pending <= 1'b1;
            end
            if (w_trans && (r_state == RED_AB)) begin
                r_next_b <= 1'b1;
            end else if (w_trans && (r_state == RED_BA)) begin
                r_next_b <= 1'b0;
            end
        end
    end

    always_comb begin
        lightA = RED;
        lightB = RED;
        walk   = 1'b0;
        case (r_state)
            A_GRN:   lightA = GRN;
            A_YEL:   lightA = YEL;
            B_GRN:   lightB = GRN;
            B_YEL:   lightB = YEL;
            WALK:    walk   = 1'b1;
            default: ;
        endcase
    end

    assign phase = r_state;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// tb/tb_traffic_intersection_ctrl.sv - directed self-checking bench for traffic_intersection_ctrl
module tb_traffic_intersection_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       sens_a;
    logic       sens_b;
    logic       ped_req;
    logic [2:0] lightA;
    logic [2:0] lightB;
    logic       walk;
    logic [2:0] phase;

    int n_checks = 0;
    int n_errors = 0;

    traffic_intersection_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .sens_a  (sens_a),
        .sens_b  (sens_b),
        .ped_req (ped_req),
        .lightA  (lightA),
        .lightB  (lightB),
        .walk    (walk),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] exp_light_a(input int p);
        case (p)
            0:       return 3'b001;
            1:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_light_b(input int p);
        case (p)
            3:       return 3'b001;
            4:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    task automatic check_phase(input string tag, input int k, input int p);
        string t;
        t = $sformatf("%s[%0d]", tag, k);
        check_eq({t, ".phase"},    phase,  p);
        check_eq({t, ".lightA"},   lightA, exp_light_a(p));
        check_eq({t, ".lightB"},   lightB, exp_light_b(p));
        check_eq({t, ".walk"},     walk,   (p == 6));
        check_eq({t, ".conflict"}, (lightA != 3'b100) && (lightB != 3'b100), 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic sa, input logic sb);
        reset   = 1'b0;
        tick    = 1'b1;
        sens_a  = sa;
        sens_b  = sb;
        ped_req = 1'b0;
        repeat (3) cycle();
        check_phase("reset", 0, 0);
        reset = 1'b1;
    endtask

    function automatic int max_green_exp(input int k);
        int p;
        p = k % 22;
        if (p < 8)  return 0;
        if (p < 10) return 1;
        if (p < 11) return 2;
        if (p < 19) return 3;
        if (p < 21) return 4;
        return 5;
    endfunction

    function automatic int ped_exp(input int k);
        if (k < 4)  return 0;
        if (k < 6)  return 1;
        if (k == 6) return 2;
        if (k < 10) return 6;
        return 3;
    endfunction

    initial begin
        int e;

        // idle: no demand keeps A green indefinitely
        do_reset(1'b0, 1'b0);
        for (int k = 1; k <= 50; k++) begin
            cycle();
            check_phase("idle", k, 0);
        end

        // basic swap: B demand only
        do_reset(1'b0, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            cycle();
            e = (k < 4) ? 0 : (k < 6) ? 1 : (k == 6) ? 2 : 3;
            check_phase("swap", k, e);
        end

        // both roads busy: max green each way, 22-cycle period
        do_reset(1'b1, 1'b1);
        for (int k = 1; k <= 44; k++) begin
            cycle();
            check_phase("maxgrn", k, max_green_exp(k));
        end

        // pedestrian pulse at cycle 2, second press during walk is dropped
        do_reset(1'b0, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            ped_req = (k == 2) || (k == 8);
            cycle();
            check_phase("ped", k, ped_exp(k));
        end
        ped_req = 1'b0;

        // tick every 4th cycle stretches every interval by four
        do_reset(1'b0, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            tick = (k % 4 == 0);
            cycle();
            e = (k < 16) ? 0 : (k < 24) ? 1 : (k < 28) ? 2 : 3;
            check_phase("tickgate", k, e);
        end
        tick = 1'b1;

        // reset in the middle of walk
        do_reset(1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            ped_req = (k == 2);
            cycle();
            check_phase("prewalk", k, ped_exp(k));
        end
        ped_req = 1'b0;
        reset   = 1'b0;
        cycle();
        check_phase("midwalk_rst", 0, 0);

        // a registered request must also be discarded by reset
        reset   = 1'b1;
        ped_req = 1'b1;
        cycle();
        check_phase("req_then_rst", 1, 0);
        ped_req = 1'b0;
        reset   = 1'b0;
        cycle();
        check_phase("req_then_rst", 2, 0);
        reset = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            check_phase("post_rst", k, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
